// File: rtl/sd_audio_pkg.sv
// Shared constants and state encoding for the SD sample streaming path.
package sd_audio_pkg;

  localparam int SECTOR_BYTES       = 512;
  localparam int SAMPLES_PER_SECTOR = 256;
  localparam int FIFO_DEPTH         = 512;
  localparam int FIFO_AW            = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECV,
    ST_SKIP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// 512 x 16 synchronous sample FIFO. Registered read port so the array maps to block RAM.
module sample_fifo
  import sd_audio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  output logic [15:0] rd_data,
  output logic [9:0]  level
);

  logic [15:0]        mem [FIFO_DEPTH];
  logic [15:0]        rd_data_q;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               do_wr, do_rd;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = rd_data_q;

  // Qualify requests and advance pointers; flush wins over everything.
  always_comb begin
    do_wr    = wr_en && (level != 10'(FIFO_DEPTH)) && !flush;
    do_rd    = rd_en && (level != 10'd0) && !flush;
    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, do_rd};
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array: one write port, one registered read port (no reset, RAM-friendly).
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
    if (do_rd) rd_data_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
  end

endmodule

// File: rtl/sd_sample_stream.sv
// Samples the SD reader byte stream, packs little-endian 16-bit PCM into a FIFO,
// steers the reader's sector address and releases one sample per SampleTick.
//
// state | meaning
// IDLE  | Play low or reset: FIFO flushed, index back to START_SECTOR
// WAIT  | between sectors, waiting for SectorEnable to rise
// RECV  | storing the first 512 bytes of the sector as samples
// SKIP  | not enough FIFO space, sector ignored and re-read next time
// DONE  | non-looping clip finished, FIFO drains, no more writes
module sd_sample_stream
  import sd_audio_pkg::*;
#(
  parameter int unsigned START_SECTOR = 0,
  parameter int unsigned SECTOR_COUNT = 4096,
  parameter bit          LOOP         = 1'b1
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        Play,
  input  logic [7:0]  SectorData,
  input  logic        SectorDataClock,
  input  logic        SectorEnable,
  output logic [23:0] InputAddress,
  input  logic        SampleTick,
  output logic [15:0] Sample,
  output logic        SampleStrobe,
  output logic [9:0]  Level,
  output logic        Underrun,
  output logic        Overrun,
  output logic        EndOfClip
);

  localparam logic [22:0] IDX_FIRST = 23'(START_SECTOR);
  localparam logic [22:0] IDX_LAST  = 23'(START_SECTOR + SECTOR_COUNT - 1);

  logic [2:0]  dclk_sync_q, dclk_sync_d;
  logic [2:0]  sen_sync_q, sen_sync_d;
  logic        byte_stb_q, byte_stb_d;
  logic        sen_rise_q, sen_rise_d;
  logic        sen_fall_q, sen_fall_d;
  logic [7:0]  data_q, data_d;

  state_t      state_q, state_d;
  logic [22:0] idx_q, idx_d, idx_next;
  logic [23:0] addr_q, addr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [7:0]  low_q, low_d;
  logic        eoc_q, eoc_d;
  logic        ovr_q, ovr_d;
  logic        fifo_wr, fifo_flush;

  logic        sel_q, sel_d;
  logic        strobe_q, strobe_d;
  logic        under_q, under_d;
  logic        pop;
  logic [15:0] fifo_rd_data;

  // Two-stage synchronizers plus a third stage for edge detection; data captured on the byte edge.
  always_comb begin
    dclk_sync_d = {dclk_sync_q[1:0], SectorDataClock};
    sen_sync_d  = {sen_sync_q[1:0], SectorEnable};
    byte_stb_d  = dclk_sync_q[1] & ~dclk_sync_q[2];
    sen_rise_d  = sen_sync_q[1] & ~sen_sync_q[2];
    sen_fall_d  = ~sen_sync_q[1] & sen_sync_q[2];
    data_d      = byte_stb_d ? SectorData : data_q;
  end

  // Sector FSM: next state, address steering, byte packing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    low_d      = low_q;
    eoc_d      = eoc_q;
    ovr_d      = 1'b0;
    fifo_wr    = 1'b0;
    fifo_flush = 1'b0;
    idx_next   = (idx_q == IDX_LAST) ? IDX_FIRST : idx_q + 23'd1;
    if (!Play || state_q == ST_IDLE) begin
      state_d    = Play ? ST_WAIT : ST_IDLE;
      fifo_flush = 1'b1;
      idx_d      = IDX_FIRST;
      addr_d     = {IDX_FIRST, 1'b0};
      cnt_d      = '0;
      eoc_d      = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (sen_rise_q) begin
            cnt_d = '0;
            if (Level <= 10'(FIFO_DEPTH - SAMPLES_PER_SECTOR)) begin
              state_d = ST_RECV;
            end else begin
              state_d = ST_SKIP;
              ovr_d   = 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (sen_fall_q) begin
            idx_d  = idx_next;
            addr_d = {idx_next, 1'b0};
            if (!LOOP && idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              eoc_d   = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (byte_stb_q && cnt_q < 10'(SECTOR_BYTES)) begin
            cnt_d = cnt_q + 10'd1;
            if (!cnt_q[0]) low_d = data_q;
            else           fifo_wr = 1'b1;
          end
        end
        ST_SKIP: begin
          if (sen_fall_q) state_d = ST_WAIT;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output side: pop on tick when data is available, otherwise play silence.
  always_comb begin
    pop      = SampleTick && (Level != 10'd0) && !fifo_flush;
    sel_d    = SampleTick ? pop : sel_q;
    strobe_d = SampleTick;
    under_d  = SampleTick && !pop;
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      dclk_sync_q <= '0;
      sen_sync_q  <= '0;
      byte_stb_q  <= 1'b0;
      sen_rise_q  <= 1'b0;
      sen_fall_q  <= 1'b0;
      data_q      <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= IDX_FIRST;
      addr_q      <= {IDX_FIRST, 1'b0};
      cnt_q       <= '0;
      low_q       <= '0;
      eoc_q       <= 1'b0;
      ovr_q       <= 1'b0;
      sel_q       <= 1'b0;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      dclk_sync_q <= dclk_sync_d;
      sen_sync_q  <= sen_sync_d;
      byte_stb_q  <= byte_stb_d;
      sen_rise_q  <= sen_rise_d;
      sen_fall_q  <= sen_fall_d;
      data_q      <= data_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      low_q       <= low_d;
      eoc_q       <= eoc_d;
      ovr_q       <= ovr_d;
      sel_q       <= sel_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
    end
  end

  sample_fifo u_fifo (
    .clk     (MasterCLK),
    .rst_n   (Reset),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data ({data_q, low_q}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (Level)
  );

  assign InputAddress = addr_q;
  assign Sample       = sel_q ? fifo_rd_data : 16'd0;
  assign SampleStrobe = strobe_q;
  assign Underrun     = under_q;
  assign Overrun      = ovr_q;
  assign EndOfClip    = eoc_q;

endmodule

// File: tb/tb_sd_sample_stream.sv
// Bench for sd_sample_stream: table of sector steps, hand-written corner sequences,
// and a randomized phase checked against a queue-based reference model.
module tb_sd_sample_stream;

  logic        clk = 1'b0;
  logic        Reset, Play, SectorDataClock, SectorEnable, SampleTick;
  logic [7:0]  SectorData;

  logic [23:0] addr_m, addr_w, addr_e;
  logic [15:0] sample_m, sample_w, sample_e;
  logic        strobe_m, strobe_w, strobe_e;
  logic [9:0]  level_m, level_w, level_e;
  logic        under_m, under_w, under_e;
  logic        ovr_m, ovr_w, ovr_e;
  logic        eoc_m, eoc_w, eoc_e;

  always #5 clk = ~clk;

  sd_sample_stream dut (
    .MasterCLK(clk), .Reset(Reset), .Play(Play), .SectorData(SectorData),
    .SectorDataClock(SectorDataClock), .SectorEnable(SectorEnable), .InputAddress(addr_m),
    .SampleTick(SampleTick), .Sample(sample_m), .SampleStrobe(strobe_m), .Level(level_m),
    .Underrun(under_m), .Overrun(ovr_m), .EndOfClip(eoc_m));

  sd_sample_stream #(.START_SECTOR(5), .SECTOR_COUNT(2), .LOOP(1'b1)) dut_w (
    .MasterCLK(clk), .Reset(Reset), .Play(Play), .SectorData(SectorData),
    .SectorDataClock(SectorDataClock), .SectorEnable(SectorEnable), .InputAddress(addr_w),
    .SampleTick(SampleTick), .Sample(sample_w), .SampleStrobe(strobe_w), .Level(level_w),
    .Underrun(under_w), .Overrun(ovr_w), .EndOfClip(eoc_w));

  sd_sample_stream #(.START_SECTOR(5), .SECTOR_COUNT(2), .LOOP(1'b0)) dut_e (
    .MasterCLK(clk), .Reset(Reset), .Play(Play), .SectorData(SectorData),
    .SectorDataClock(SectorDataClock), .SectorEnable(SectorEnable), .InputAddress(addr_e),
    .SampleTick(SampleTick), .Sample(sample_e), .SampleStrobe(strobe_e), .Level(level_e),
    .Underrun(under_e), .Overrun(ovr_e), .EndOfClip(eoc_e));

  int n_cmp = 0;
  int n_fail = 0;
  int ovr_seen = 0;

  // reference model for the default-parameter DUT
  logic [15:0] q[$];
  int          idx = 0;
  localparam int M_START = 0;
  localparam int M_COUNT = 4096;

  typedef struct {
    int          nbytes;
    int          ticks;
    logic [9:0]  lvl;
    logic [23:0] addr;
    int          ovr;
    logic [23:0] addr_w;
    logic        eoc_e;
    logic [9:0]  lvl_e;
  } step_t;

  step_t steps[5];

  always @(negedge clk) if (ovr_m) ovr_seen++;

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete, cycles 150000 required fewer");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    SectorData = b;
    SectorDataClock = 1'b1;
    repeat (3) @(posedge clk);
    #1 SectorDataClock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    logic [15:0] exp_s;
    logic        exp_u;
    @(posedge clk); #1 SampleTick = 1'b1;
    @(posedge clk); #1 SampleTick = 1'b0;
    if (q.size() > 0) begin exp_s = q.pop_front(); exp_u = 1'b0; end
    else begin exp_s = 16'h0000; exp_u = 1'b1; end
    chk("tick_sample", 32'(sample_m), 32'(exp_s));
    chk("tick_strobe", 32'(strobe_m), 32'd1);
    chk("tick_underrun", 32'(under_m), 32'(exp_u));
    chk("tick_level", 32'(level_m), 32'(q.size()));
  endtask

  // one sector; the model decides acceptance from queue occupancy at the window start
  task automatic send_sector(input int n, input bit rnd, input bit tick_rnd, output bit acc);
    logic [7:0] b, lo;
    lo = 8'h00;
    @(posedge clk); #1 SectorEnable = 1'b1;
    repeat (4) @(posedge clk);
    acc = (q.size() <= 256);
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      send_byte(b);
      if (acc && i < 512) begin
        if (i % 2 == 0) lo = b;
        else q.push_back({b, lo});
      end
      if (tick_rnd && $urandom_range(0, 2) == 0) do_tick();
    end
    @(posedge clk); #1 SectorEnable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    if (acc) idx = (idx == M_START + M_COUNT - 1) ? M_START : idx + 1;
  endtask

  initial begin
    bit acc;
    int base;
    steps[0] = '{514,   0, 10'd256, 24'h000002, 0, 24'h00000C, 1'b0, 10'd256};
    steps[1] = '{514,   0, 10'd512, 24'h000004, 0, 24'h00000A, 1'b1, 10'd512};
    steps[2] = '{514,   0, 10'd512, 24'h000004, 1, 24'h00000A, 1'b1, 10'd512};
    steps[3] = '{0,   513, 10'd0,   24'h000004, 0, 24'h00000A, 1'b1, 10'd0};
    steps[4] = '{514,   0, 10'd256, 24'h000006, 0, 24'h00000C, 1'b1, 10'd0};

    Reset = 1'b0; Play = 1'b0; SectorData = 8'h00; SectorDataClock = 1'b0;
    SectorEnable = 1'b0; SampleTick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr_m), 32'h0);
    chk("rst_sample", 32'(sample_m), 32'h0);
    chk("rst_level", 32'(level_m), 32'h0);
    chk("rst_flags", 32'({strobe_m, under_m, ovr_m, eoc_m}), 32'h0);
    chk("rst_addr_w", 32'(addr_w), 32'h0A);
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Play = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int s = 0; s < 5; s++) begin
      base = ovr_seen;
      if (steps[s].nbytes > 0) send_sector(steps[s].nbytes, 1'b0, 1'b0, acc);
      for (int t = 0; t < steps[s].ticks; t++) do_tick();
      chk($sformatf("step%0d_level", s), 32'(level_m), 32'(steps[s].lvl));
      chk($sformatf("step%0d_model_level", s), 32'(level_m), 32'(q.size()));
      chk($sformatf("step%0d_addr", s), 32'(addr_m), 32'(steps[s].addr));
      chk($sformatf("step%0d_overrun", s), 32'(ovr_seen - base), 32'(steps[s].ovr));
      chk($sformatf("step%0d_addr_wrap", s), 32'(addr_w), 32'(steps[s].addr_w));
      chk($sformatf("step%0d_eoc", s), 32'(eoc_e), 32'(steps[s].eoc_e));
      chk($sformatf("step%0d_level_eoc", s), 32'(level_e), 32'(steps[s].lvl_e));
    end

    // abort in the middle of a sector
    @(posedge clk); #1 SectorEnable = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 100; i++) send_byte(8'(i));
    Play = 1'b0;
    @(posedge clk); #1;
    chk("abort_level", 32'(level_m), 32'h0);
    chk("abort_addr", 32'(addr_m), 32'h0);
    chk("abort_addr_w", 32'(addr_w), 32'h0A);
    chk("abort_eoc_cleared", 32'(eoc_e), 32'h0);
    for (int i = 100; i < 514; i++) send_byte(8'(i));
    @(posedge clk); #1 SectorEnable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_ignored_level", 32'(level_m), 32'h0);
    q.delete();
    idx = M_START;

    // simultaneous FIFO write and pop at Level=1
    Play = 1'b1;
    repeat (3) @(posedge clk);
    #1 SectorEnable = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(8'h00);
    send_byte(8'h01);
    chk("simul_level1", 32'(level_m), 32'd1);
    send_byte(8'h02);
    @(posedge clk); #1;
    SectorData = 8'h03;
    SectorDataClock = 1'b1;
    repeat (3) @(posedge clk);
    #1 SampleTick = 1'b1;
    chk("simul_level_before", 32'(level_m), 32'd1);
    @(posedge clk); #1 SampleTick = 1'b0;
    chk("simul_level_after", 32'(level_m), 32'd1);
    chk("simul_sample_older", 32'(sample_m), 32'h0100);
    chk("simul_strobe", 32'(strobe_m), 32'd1);
    chk("simul_no_underrun", 32'(under_m), 32'd0);
    SectorDataClock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    q.push_back(16'h0302);
    do_tick();
    @(posedge clk); #1 SectorEnable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idx = idx + 1;
    chk("short_sector_addr", 32'(addr_m), 32'(idx * 2));

    // randomized sectors with random ticks, checked against the queue model
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 530);
      base = ovr_seen;
      send_sector(n, 1'b1, 1'b1, acc);
      chk($sformatf("rnd%0d_addr", s), 32'(addr_m), 32'(idx * 2));
      chk($sformatf("rnd%0d_level", s), 32'(level_m), 32'(q.size()));
      chk($sformatf("rnd%0d_overrun", s), 32'(ovr_seen - base), acc ? 32'd0 : 32'd1);
      for (int t = $urandom_range(0, 40); t > 0; t--) do_tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
